seq_ir_fetch: RTL

Opcode fetch and instruction-register stage sitting directly upstream of the sequencer. It captures the opcode byte from the internal data bus at the end of each M1 cycle and drives IR[7:0] into the sequencer/decoder. It also tracks the CB prefix, forces the interrupt-dispatch opcode, and holds the core in HALT/STOP. It generates the PC-increment qualifier, including the HALT-bug suppression.

---
 rtl/seq_ir_fetch_if.sv | 27 ++
 rtl/seq_ir_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_ir_fetch_if.sv
// Handshake bundle between the opcode-fetch stage and its surroundings.
// slave: seq_ir_fetch side; master: the driving core/bench side.
interface seq_ir_fetch_if;
  logic [7:0] DBUS;
  logic       M1_END;
  logic       OP_DONE;
  logic       INT_PENDING;
  logic       IME;
  logic       WAKE;
  logic [7:0] IR;
  logic       CB_MODE;
  logic       INT_SEQ;
  logic       HALTED;
  logic       STOPPED;
  logic       PC_INC;
  logic       IR_VALID;

  modport slave (
    input  DBUS, M1_END, OP_DONE, INT_PENDING, IME, WAKE,
    output IR, CB_MODE, INT_SEQ, HALTED, STOPPED, PC_INC, IR_VALID
  );

  modport master (
    output DBUS, M1_END, OP_DONE, INT_PENDING, IME, WAKE,
    input  IR, CB_MODE, INT_SEQ, HALTED, STOPPED, PC_INC, IR_VALID
  );
endinterface

// File: rtl/seq_ir_fetch.sv
// Opcode fetch / instruction register stage with CB prefix, interrupt dispatch and HALT/STOP.
// Optional macro SEQ_IR_FETCH_HALT_BUG_EN: HALT with IME=0 and a pending interrupt skips the next PC increment.
module seq_ir_fetch #(
  parameter logic [7:0] INT_OPCODE = 8'h00,
  parameter logic [7:0] OP_HALT    = 8'h76,
  parameter logic [7:0] OP_STOP    = 8'h10,
  parameter logic [7:0] OP_CB      = 8'hCB
) (
  input  logic          CLK,
  input  logic          nRESET,
  seq_ir_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_CBPRE = 3'd1,
    ST_INTP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t     state_r, state_nxt_s, mid_state_s;
  logic [7:0] ir_r, ir_nxt_s;
  logic       cb_mode_r, cb_mode_nxt_s;
  logic       int_seq_r, int_seq_nxt_s;
  logic       pc_inc_r, pc_inc_nxt_s;
  logic       ir_valid_r, ir_valid_nxt_s;
  logic       halted_r, stopped_r;
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
  logic       halt_bug_r, halt_bug_nxt_s;
`endif

  // Next-state: retire decision first, then the fetch is handled under the resulting state.
  always_comb begin
    mid_state_s    = state_r;
    state_nxt_s    = state_r;
    ir_nxt_s       = ir_r;
    cb_mode_nxt_s  = cb_mode_r;
    int_seq_nxt_s  = int_seq_r;
    pc_inc_nxt_s   = 1'b0;
    ir_valid_nxt_s = 1'b0;
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
    halt_bug_nxt_s = halt_bug_r;
`endif

    if (bus.OP_DONE && (state_r != ST_CBPRE)) begin
      cb_mode_nxt_s = 1'b0;
      int_seq_nxt_s = 1'b0;
      if (state_r == ST_RUN) begin
        if (bus.IME && bus.INT_PENDING) begin
          mid_state_s = ST_INTP;
        end else if ((ir_r == OP_HALT) && !cb_mode_r) begin
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
          if (bus.INT_PENDING && !bus.IME) begin
            halt_bug_nxt_s = 1'b1;
          end else begin
            mid_state_s = ST_HALT;
          end
`else
          mid_state_s = (bus.INT_PENDING && !bus.IME) ? ST_RUN : ST_HALT;
`endif
        end else if ((ir_r == OP_STOP) && !cb_mode_r) begin
          mid_state_s = ST_STOP;
        end else begin
          mid_state_s = ST_RUN;
        end
      end else begin
        mid_state_s = state_r;
      end
    end else begin
      mid_state_s = state_r;
    end

    state_nxt_s = mid_state_s;
    case (mid_state_s)
      ST_RUN: begin
        if (bus.M1_END) begin
          ir_nxt_s       = bus.DBUS;
          cb_mode_nxt_s  = 1'b0;
          ir_valid_nxt_s = 1'b1;
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
          pc_inc_nxt_s   = !halt_bug_nxt_s;
          halt_bug_nxt_s = 1'b0;
`else
          pc_inc_nxt_s   = 1'b1;
`endif
          state_nxt_s    = (bus.DBUS == OP_CB) ? ST_CBPRE : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CBPRE: begin
        if (bus.M1_END) begin
          ir_nxt_s       = bus.DBUS;
          cb_mode_nxt_s  = 1'b1;
          pc_inc_nxt_s   = 1'b1;
          ir_valid_nxt_s = 1'b1;
          state_nxt_s    = ST_RUN;
        end else begin
          state_nxt_s = ST_CBPRE;
        end
      end
      ST_INTP: begin
        if (bus.M1_END) begin
          ir_nxt_s       = INT_OPCODE;
          int_seq_nxt_s  = 1'b1;
          cb_mode_nxt_s  = 1'b0;
          ir_valid_nxt_s = 1'b1;
          state_nxt_s    = ST_RUN;
        end else begin
          state_nxt_s = ST_INTP;
        end
      end
      ST_HALT: begin
        // Wake only from a HALT already held; a HALT entered this cycle waits one cycle.
        if ((state_r == ST_HALT) && bus.INT_PENDING) begin
          state_nxt_s = bus.IME ? ST_INTP : ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_STOP: begin
        if ((state_r == ST_STOP) && bus.WAKE) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_r    <= ST_RUN;
      ir_r       <= 8'h00;
      cb_mode_r  <= 1'b0;
      int_seq_r  <= 1'b0;
      pc_inc_r   <= 1'b0;
      ir_valid_r <= 1'b0;
      halted_r   <= 1'b0;
      stopped_r  <= 1'b0;
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
      halt_bug_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      ir_r       <= ir_nxt_s;
      cb_mode_r  <= cb_mode_nxt_s;
      int_seq_r  <= int_seq_nxt_s;
      pc_inc_r   <= pc_inc_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
      halted_r   <= (state_nxt_s == ST_HALT);
      stopped_r  <= (state_nxt_s == ST_STOP);
`ifdef SEQ_IR_FETCH_HALT_BUG_EN
      halt_bug_r <= halt_bug_nxt_s;
`endif
    end
  end

  assign bus.IR       = ir_r;
  assign bus.CB_MODE  = cb_mode_r;
  assign bus.INT_SEQ  = int_seq_r;
  assign bus.HALTED   = halted_r;
  assign bus.STOPPED  = stopped_r;
  assign bus.PC_INC   = pc_inc_r;
  assign bus.IR_VALID = ir_valid_r;

endmodule
